// File: rtl/corr_lag_accum.sv
// corr_lag_accum: per-lag multiply-accumulate of delayed samples into a RAM, with a host read port
module corr_lag_accum #(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sin,
    input  logic [DW-1:0]    din_cur,
    input  logic [DW-1:0]    dshift,
    input  logic             dshift_vld,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [ACC_W-1:0] rd_data,
    output logic             rd_vld,
    output logic [31:0]      n_samp,
    output logic             busy,
    output logic             sat,
    output logic             err
);
    localparam int N = 1 << AW;

    typedef enum logic [1:0] {CLEAR, IDLE, ACCUM, FLUSH} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     cnt, lag, lag1, lag2;
    logic              v1, v2;
    logic [2*DW-1:0]   prod1;
    logic [ACC_W-1:0]  sum2;
    logic [ACC_W-1:0]  mem [N];
    logic [ACC_W:0]    sum_raw;
    logic              beat, done, rd_acc, err_set;

    assign busy = state != IDLE;

    always_comb begin
        beat     = state == ACCUM && dshift_vld && !sin && !clr;
        done     = v2 && &lag2;
        rd_acc   = state == IDLE && rd_en && !clr;
        err_set  = !clr && ((sin && (state == ACCUM || state == CLEAR)) ||
                            (dshift_vld && (state == IDLE || state == CLEAR)));
        // accumulator fetched in the sum stage so a restarted burst sees the partial burst's writes
        sum_raw  = {1'b0, mem[lag1]} + (ACC_W+1)'(prod1);
        state_nx = state;
        case (state)
            CLEAR:   state_nx = &cnt ? IDLE : CLEAR;
            IDLE:    state_nx = sin ? ACCUM : IDLE;
            ACCUM:   state_nx = (beat && &lag) ? FLUSH : ACCUM;
            default: state_nx = done ? IDLE : FLUSH;
        endcase
        if (clr) state_nx = CLEAR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= '0;
            lag     <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            rd_data <= '0;
            rd_vld  <= 1'b0;
            n_samp  <= '0;
            sat     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= (state == CLEAR && !clr) ? cnt + 1'b1 : '0;
            lag    <= (clr || (sin && (state == IDLE || state == ACCUM))) ? '0 : beat ? lag + 1'b1 : lag;
            v1     <= beat;
            v2     <= v1 && !clr;
            sat    <= !clr && (sat || (v1 && sum_raw[ACC_W]));
            err    <= !clr && (err || err_set);
            n_samp <= clr ? '0 : (done && ~&n_samp) ? n_samp + 32'd1 : n_samp;
            rd_vld <= rd_acc;
            if (rd_acc) rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        lag1  <= lag;
        lag2  <= lag1;
        prod1 <= (2*DW)'(din_cur) * (2*DW)'(dshift);
        sum2  <= sum_raw[ACC_W] ? '1 : sum_raw[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[cnt] <= '0;
        else if (v2 && !clr) mem[lag2] <= sum2;
    end
endmodule
